// File: rtl/ysyx_22040759_ifu_axi_rd_pkg.sv
// rtl/ysyx_22040759_ifu_axi_rd_pkg.sv - shared FSM encodings and AXI constants for the IF read master
//
// Purpose: state encoding of the fetch FSM and the fixed AXI4 read-channel
// field values used by ysyx_22040759_ifu_axi_rd.
// Ports: none (package).
package ysyx_22040759_ifu_axi_rd_pkg;

  typedef enum logic [2:0] {
    IFR_IDLE  = 3'd0,
    IFR_ADDR  = 3'd1,
    IFR_DATA  = 3'd2,
    IFR_DONE  = 3'd3,
    IFR_DRAIN = 3'd4
  } ifr_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/ysyx_22040759_ifu_axi_rd.sv
// rtl/ysyx_22040759_ifu_axi_rd.sv - single-beat AXI4 instruction fetch read master
//
// Purpose: takes one fetch request at a time from IF, issues one 8-byte AXI
// read for the enclosing doubleword, returns the selected 32-bit lane.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   if_valid, inst_addr    fetch request from IF
//   flush                  discard current fetch (taken branch)
//   if_ready, if_data_read fetch result ({32'h0, instruction})
//   if_err                 sticky error (bad r_resp or r_id)
//   ar_*                   AXI read address channel
//   r_*                    AXI read data channel
module ysyx_22040759_ifu_axi_rd
  import ysyx_22040759_ifu_axi_rd_pkg::*;
#(
  parameter logic [3:0]  AXI_ID  = 4'd0,
  parameter logic [31:0] RST_NOP = 32'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [63:0] inst_addr,
  input  logic        flush,
  output logic        if_ready,
  output logic [63:0] if_data_read,
  output logic        if_err,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [3:0]  ar_id,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic [3:0]  r_id
);

  ifr_state_e  state, next_state;
  logic        lane;
  logic        flush_seen;
  logic [31:0] data_q;
  logic        err_q;
  logic        beat_ok;
  logic        drop;
  logic        unused_ok;

  // r_last carries no information for a single-beat burst; the low address
  // bits are implied by 4-byte alignment.
  assign unused_ok = ^{r_last, inst_addr[1:0]};

  assign beat_ok = (r_resp == RESP_OKAY) && (r_id == AXI_ID);
  // A flush seen at any point since the request makes the result stale.
  assign drop    = flush | flush_seen;

  always_ff @(posedge clk) begin
    if (rst) state <= IFR_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    if_ready   = 1'b0;
    case (state)
      IFR_IDLE: begin
        if (if_valid && !flush) next_state = IFR_ADDR;
      end
      IFR_ADDR: begin
        // The AR cannot be retracted once raised, so a flush here only
        // redirects the returning beat into DRAIN.
        ar_valid = 1'b1;
        if (ar_ready) next_state = drop ? IFR_DRAIN : IFR_DATA;
      end
      IFR_DATA: begin
        r_ready = 1'b1;
        if (r_valid) next_state = drop ? IFR_IDLE : IFR_DONE;
      end
      IFR_DONE: begin
        if_ready = 1'b1;
        if (flush || if_valid) next_state = IFR_IDLE;
      end
      IFR_DRAIN: begin
        r_ready = 1'b1;
        if (r_valid) next_state = IFR_IDLE;
      end
      default: next_state = IFR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr    <= 64'h0;
      lane       <= 1'b0;
      flush_seen <= 1'b0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (state == IFR_IDLE && if_valid && !flush) begin
        ar_addr <= {inst_addr[63:3], 3'b000};
        lane    <= inst_addr[2];
      end

      if (next_state == IFR_IDLE)
        flush_seen <= 1'b0;
      else if ((state == IFR_ADDR || state == IFR_DATA) && flush)
        flush_seen <= 1'b1;

      if (state == IFR_DATA && r_valid) begin
        if (!beat_ok) err_q <= 1'b1;
        if (!drop)
          data_q <= !beat_ok ? RST_NOP : (lane ? r_data[63:32] : r_data[31:0]);
      end
    end
  end

  assign if_data_read = {32'h0, data_q};
  assign if_err       = err_q;
  assign ar_id        = AXI_ID;
  assign ar_len       = LEN_SINGLE;
  assign ar_size      = SIZE_8B;
  assign ar_burst     = BURST_INCR;

endmodule

// File: tb/tb_ysyx_22040759_ifu_axi_rd.sv
// tb/tb_ysyx_22040759_ifu_axi_rd.sv - self-checking bench for the IF AXI read master
module tb_ysyx_22040759_ifu_axi_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [63:0] inst_addr;
  logic        flush;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic        if_err;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  always #5 clk = ~clk;

  ysyx_22040759_ifu_axi_rd dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .inst_addr(inst_addr), .flush(flush),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_err(if_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  rid;
    int          ar_wait;
    int          r_wait;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [63:0] exp_q[$];
  logic        err_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; flush = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
  endtask

  task automatic fetch(input vec_t v);
    int cyc, waits, rwaits;
    bit done;
    logic [63:0] held;
    @(negedge clk);
    if_valid  = 1'b1;
    inst_addr = v.addr;
    exp_q.push_back({32'h0, v.exp_data});
    err_q.push_back(v.exp_err);
    cyc = 0; waits = 0; rwaits = 0; done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (ar_valid) begin
        check("ar_addr", ar_addr, v.addr & ~64'h7);
        if (waits == v.ar_wait) ar_ready = 1'b1;
        else waits++;
      end
      if (r_ready) begin
        if (rwaits == v.r_wait) begin
          r_valid = 1'b1; r_data = v.rdata; r_resp = v.resp; r_id = v.rid;
        end else rwaits++;
      end
      if (if_ready) begin
        done = 1;
        check("latency", 64'(cyc), 64'(3 + v.ar_wait + v.r_wait));
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard: unexpected if_ready, nothing queued");
        end else begin
          check("if_data_read", if_data_read, exp_q.pop_front());
          check("if_err", 64'(if_err), 64'(err_q.pop_front()));
        end
        held = if_data_read;
        for (int h = 0; h < v.hold; h++) begin
          @(negedge clk);
          check("done_hold_ready", 64'(if_ready), 64'd1);
          check("done_hold_data", if_data_read, held);
        end
        if_valid = 1'b1;
        @(negedge clk);
        if_valid = 1'b0;
        check("ready_after_handshake", 64'(if_ready), 64'd0);
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL fetch_timeout: got no if_ready expected if_ready within 100 cycles");
    end
  endtask

  initial begin
    vecs[0] = '{64'h8000_0000, 64'h1111_1111_0000_0513, 2'b00, 4'h0, 0, 0, 0, 32'h0000_0513, 1'b0};
    vecs[1] = '{64'h8000_0004, 64'h1111_1111_0000_0513, 2'b00, 4'h0, 0, 0, 0, 32'h1111_1111, 1'b0};
    vecs[2] = '{64'h8000_0108, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 4'h0, 5, 0, 0, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{64'h8000_010C, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 4'h0, 1, 2, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{64'h8000_0010, 64'h0123_4567_89AB_CDEF, 2'b00, 4'h0, 0, 0, 3, 32'h89AB_CDEF, 1'b0};
    vecs[5] = '{64'h8000_0020, 64'h5555_5555_6666_6666, 2'b10, 4'h0, 0, 0, 0, 32'h0000_0013, 1'b1};
    vecs[6] = '{64'h8000_0024, 64'h7777_7777_8888_8888, 2'b00, 4'h0, 0, 0, 0, 32'h7777_7777, 1'b1};
    vecs[7] = '{64'h8000_0028, 64'h9999_9999_AAAA_AAAA, 2'b00, 4'h3, 0, 0, 0, 32'h0000_0013, 1'b1};

    idle_inputs();
    inst_addr = 64'h0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b1; r_id = 4'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ar_valid", 64'(ar_valid), 64'd0);
    check("rst_r_ready", 64'(r_ready), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd0);
    check("rst_if_data_read", if_data_read, 64'h0);
    check("rst_if_err", 64'(if_err), 64'd0);
    check("rst_ar_addr", ar_addr, 64'h0);
    check("ar_len", 64'(ar_len), 64'd0);
    check("ar_size", 64'(ar_size), 64'd3);
    check("ar_burst", 64'(ar_burst), 64'd1);
    check("ar_id", 64'(ar_id), 64'd0);

    for (int i = 0; i < 5; i++) fetch(vecs[i]);

    // flush while the AR is still waiting: AR completes, beat drained, no output
    @(negedge clk);
    if_valid = 1'b1; inst_addr = 64'h8000_0040;
    @(negedge clk);
    if_valid = 1'b0; flush = 1'b1;
    check("flushA_ar_valid", 64'(ar_valid), 64'd1);
    @(negedge clk);
    flush = 1'b0; ar_ready = 1'b1;
    check("flushA_ar_kept", 64'(ar_valid), 64'd1);
    check("flushA_ar_addr", ar_addr, 64'h8000_0040);
    @(negedge clk);
    ar_ready = 1'b0;
    check("flushA_drain_r_ready", 64'(r_ready), 64'd1);
    check("flushA_drain_if_ready", 64'(if_ready), 64'd0);
    r_valid = 1'b1; r_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    r_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("flushA_idle_r_ready", 64'(r_ready), 64'd0);
      check("flushA_idle_ar_valid", 64'(ar_valid), 64'd0);
      check("flushA_idle_if_ready", 64'(if_ready), 64'd0);
      @(negedge clk);
    end

    // flush coincident with the R beat: result discarded
    if_valid = 1'b1; inst_addr = 64'h8000_0048;
    @(negedge clk);
    if_valid = 1'b0; ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    check("flushB_r_ready", 64'(r_ready), 64'd1);
    r_valid = 1'b1; flush = 1'b1; r_data = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    r_valid = 1'b0; flush = 1'b0;
    check("flushB_if_ready", 64'(if_ready), 64'd0);
    check("flushB_r_ready_idle", 64'(r_ready), 64'd0);
    check("flushB_ar_valid_idle", 64'(ar_valid), 64'd0);

    // flush while the result is waiting in DONE
    @(negedge clk);
    if_valid = 1'b1; inst_addr = 64'h8000_0050;
    @(negedge clk);
    if_valid = 1'b0; ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h0000_0000_0040_0093;
    @(negedge clk);
    r_valid = 1'b0;
    check("flushC_if_ready", 64'(if_ready), 64'd1);
    check("flushC_data", if_data_read, 64'h0040_0093);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flushC_dropped", 64'(if_ready), 64'd0);

    for (int i = 5; i < 8; i++) fetch(vecs[i]);
    repeat (2) @(negedge clk);
    check("err_sticky", 64'(if_err), 64'd1);

    // reset mid-transaction, then a stale beat in IDLE
    if_valid = 1'b1; inst_addr = 64'h8000_0060;
    @(negedge clk);
    if_valid = 1'b0;
    check("rstD_ar_valid_before", 64'(ar_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstD_ar_valid", 64'(ar_valid), 64'd0);
    check("rstD_if_err", 64'(if_err), 64'd0);
    check("rstD_r_ready", 64'(r_ready), 64'd0);
    r_valid = 1'b1; r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    r_valid = 1'b0;
    check("rstD_if_ready", 64'(if_ready), 64'd0);
    check("rstD_data", if_data_read, 64'h0);

    fetch(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
